card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/blackjack_pkg.sv | 21 ++
 rtl/card_index_decode.sv | 21 ++
 rtl/card_dealer.sv | 127 ++++++++++++
 tb/tb_card_dealer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared deck constants, dealer FSM state encoding and the decoded card type.
package blackjack_pkg;

    localparam int unsigned DECK_SIZE      = 52;
    localparam int unsigned RANKS_PER_SUIT = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAPTURE,
        ST_PROBE,
        ST_PRESENT,
        ST_EMPTY
    } state_t;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
    } card_t;

endpackage

// File: rtl/card_index_decode.sv
// Combinational card index to (rank, suit) mapping: rank = idx%13+1, suit = idx/13.
module card_index_decode
    import blackjack_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] index,
    output card_t            card
);

    logic [WIDTH-1:0] rank_m;
    logic [WIDTH-1:0] suit_m;

    always_comb begin
        rank_m    = index % WIDTH'(RANKS_PER_SUIT);
        suit_m    = index / WIDTH'(RANKS_PER_SUIT);
        card.rank = 4'(rank_m) + 4'd1;
        card.suit = 2'(suit_m);
    end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: draws a random index, probes the dealt mask linearly for a free card.
// Optional DEALER_PROBE_STATS_EN adds o_probe_cycles (PROBE cycles of the last card).
module card_dealer #(
    parameter int unsigned DECK_SIZE = blackjack_pkg::DECK_SIZE,
    parameter int unsigned WIDTH     = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_deal,
    input  logic             i_shuffle,
    output logic             o_rng_request,
    output logic [WIDTH-1:0] o_rng_max,
    input  logic [WIDTH-1:0] i_rng_value,
    output logic             o_card_valid,
    output logic [3:0]       o_card_rank,
    output logic [1:0]       o_card_suit,
    input  logic             i_card_ack,
    output logic             o_busy,
    output logic             o_deck_empty,
    output logic [WIDTH-1:0] o_dealt_count
`ifdef DEALER_PROBE_STATS_EN
   ,output logic [WIDTH-1:0] o_probe_cycles
`endif
);

    import blackjack_pkg::*;

    state_t               state_q, state_d;
    logic [DECK_SIZE-1:0] mask_q;
    logic [WIDTH-1:0]     count_q;
    logic [WIDTH-1:0]     cand_q;
    logic                 empty_q;
    card_t                card_q;
    card_t                cand_card;
    logic                 do_shuffle;
    logic                 probe_hit;

    card_index_decode #(.WIDTH(WIDTH)) u_decode (
        .index (cand_q),
        .card  (cand_card)
    );

    always_comb begin
        do_shuffle = i_shuffle && (state_q == ST_IDLE || state_q == ST_EMPTY);
        probe_hit  = (state_q == ST_PROBE) && !mask_q[cand_q];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (do_shuffle)
                    state_d = ST_IDLE;
                else if (i_deal && count_q < WIDTH'(DECK_SIZE))
                    state_d = ST_REQ;
            end
            ST_REQ:     state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_PROBE;
            ST_PROBE:   if (probe_hit) state_d = ST_PRESENT;
            ST_PRESENT: begin
                if (i_card_ack)
                    state_d = (count_q == WIDTH'(DECK_SIZE)) ? ST_EMPTY : ST_IDLE;
            end
            ST_EMPTY:   if (do_shuffle) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            count_q <= '0;
            cand_q  <= '0;
            empty_q <= 1'b0;
            card_q  <= '0;
        end else begin
            state_q <= state_d;
            if (do_shuffle) begin
                mask_q  <= '0;
                count_q <= '0;
                empty_q <= 1'b0;
            end
            if (state_q == ST_CAPTURE)
                cand_q <= (i_rng_value >= WIDTH'(DECK_SIZE)) ? i_rng_value - WIDTH'(DECK_SIZE)
                                                             : i_rng_value;
            if (probe_hit) begin
                mask_q[cand_q] <= 1'b1;
                count_q        <= count_q + 1'b1;
                // empty flag tracks the incremented count so it never lags o_dealt_count
                empty_q        <= (count_q == WIDTH'(DECK_SIZE - 1));
                card_q         <= cand_card;
            end else if (state_q == ST_PROBE) begin
                cand_q <= (cand_q == WIDTH'(DECK_SIZE - 1)) ? '0 : cand_q + 1'b1;
            end
        end
    end

`ifdef DEALER_PROBE_STATS_EN
    logic [WIDTH-1:0] probe_run_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            probe_run_q    <= '0;
            o_probe_cycles <= '0;
        end else if (state_q == ST_CAPTURE) begin
            probe_run_q <= '0;
        end else if (state_q == ST_PROBE) begin
            probe_run_q <= probe_run_q + 1'b1;
            if (probe_hit)
                o_probe_cycles <= probe_run_q + 1'b1;
        end
    end
`endif

    always_comb begin
        o_rng_request = (state_q == ST_REQ);
        o_rng_max     = WIDTH'(DECK_SIZE - 1);
        o_card_valid  = (state_q == ST_PRESENT);
        o_card_rank   = card_q.rank;
        o_card_suit   = card_q.suit;
        o_busy        = (state_q != ST_IDLE) && (state_q != ST_EMPTY);
        o_deck_empty  = empty_q;
        o_dealt_count = count_q;
    end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer against a set-of-dealt-cards reference model.
module tb_card_dealer;

    localparam int N = 52;
    localparam int W = 6;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_deal;
    logic         i_shuffle;
    logic         o_rng_request;
    logic [W-1:0] o_rng_max;
    logic [W-1:0] i_rng_value;
    logic         o_card_valid;
    logic [3:0]   o_card_rank;
    logic [1:0]   o_card_suit;
    logic         i_card_ack;
    logic         o_busy;
    logic         o_deck_empty;
    logic [W-1:0] o_dealt_count;
`ifdef DEALER_PROBE_STATS_EN
    logic [W-1:0] o_probe_cycles;
`endif

    card_dealer #(.DECK_SIZE(N), .WIDTH(W)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_deal        (i_deal),
        .i_shuffle     (i_shuffle),
        .o_rng_request (o_rng_request),
        .o_rng_max     (o_rng_max),
        .i_rng_value   (i_rng_value),
        .o_card_valid  (o_card_valid),
        .o_card_rank   (o_card_rank),
        .o_card_suit   (o_card_suit),
        .i_card_ack    (i_card_ack),
        .o_busy        (o_busy),
        .o_deck_empty  (o_deck_empty),
        .o_dealt_count (o_dealt_count)
`ifdef DEALER_PROBE_STATS_EN
       ,.o_probe_cycles(o_probe_cycles)
`endif
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    // reference model: which cards are out, how many, and the card being presented
    bit used [N];
    int m_count  = 0;
    bit m_active = 1'b0;
    int m_rank   = 0;
    int m_suit   = 0;
    bit seen [N];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            check("rng_max", int'(o_rng_max), N - 1);
            check("dealt_count", int'(o_dealt_count), m_count);
            check("deck_empty", int'(o_deck_empty), int'(m_count == N));
            if (o_card_valid) begin
                check("valid_when_expected", int'(m_active), 1);
                check("model_rank", int'(o_card_rank), m_rank);
                check("model_suit", int'(o_card_suit), m_suit);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        m_count  = 0;
        m_active = 1'b0;
    endtask

    task automatic shuffle();
        i_shuffle = 1'b1;
        @(posedge i_clk); #1;
        i_shuffle = 1'b0;
        model_clear();
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        check("shuffle_busy", int'(o_busy), 0);
    endtask

    task automatic deal(input int v, input int hold, input bit poke,
                        output int rank, output int suit, output int lat);
        int c;
        int d;
        int cyc;
        int idx;
        c = (v >= N) ? v - N : v;
        d = 0;
        while (used[c]) begin
            c = (c + 1) % N;
            d++;
        end
        m_rank = c % 13 + 1;
        m_suit = c / 13;
        check("busy_before_deal", int'(o_busy), 0);
        i_rng_value = W'(v);
        i_deal = 1'b1;
        @(posedge i_clk); #1;
        i_deal = 1'b0;
        m_active = 1'b1;
        check("rng_request_pulse", int'(o_rng_request), 1);
        cyc = 0;
        while (!o_card_valid && cyc < 80) begin
            @(posedge i_clk); #1;
            cyc++;
            check("rng_request_single", int'(o_rng_request), 0);
        end
        lat = cyc;
        check("latency", cyc, 3 + d);
        if (o_card_valid) begin
            used[c] = 1'b1;
            m_count++;
        end
`ifdef DEALER_PROBE_STATS_EN
        check("probe_cycles", int'(o_probe_cycles), d + 1);
`endif
        rank = int'(o_card_rank);
        suit = int'(o_card_suit);
        idx  = suit * 13 + rank - 1;
        if (idx >= 0 && idx < N) begin
            check("distinct_card", int'(seen[idx]), 0);
            seen[idx] = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                i_deal    = (h % 2 == 0);
                i_shuffle = (h % 2 == 1);
            end
            @(posedge i_clk); #1;
            i_deal    = 1'b0;
            i_shuffle = 1'b0;
            check("hold_valid", int'(o_card_valid), 1);
            check("hold_rank", int'(o_card_rank), rank);
            check("hold_suit", int'(o_card_suit), suit);
            check("hold_no_request", int'(o_rng_request), 0);
        end
        i_card_ack = 1'b1;
        @(posedge i_clk); #1;
        i_card_ack = 1'b0;
        m_active = 1'b0;
        check("valid_after_ack", int'(o_card_valid), 0);
        check("busy_after_ack", int'(o_busy), 0);
    endtask

    initial begin
        int r, s, l;
        i_rst_n = 1'b0; i_deal = 1'b0; i_shuffle = 1'b0; i_card_ack = 1'b0; i_rng_value = '0;
        model_clear();
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_rng_request", int'(o_rng_request), 0);
        check("rst_valid", int'(o_card_valid), 0);
        check("rst_rank", int'(o_card_rank), 0);
        check("rst_suit", int'(o_card_suit), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_empty", int'(o_deck_empty), 0);
        check("rst_count", int'(o_dealt_count), 0);
`ifdef DEALER_PROBE_STATS_EN
        check("rst_probe_cycles", int'(o_probe_cycles), 0);
`endif
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        deal(0, 0, 1'b0, r, s, l);
        check("lit_v0_rank", r, 1);
        check("lit_v0_suit", s, 0);
        check("lit_v0_latency", l, 3);
        check("lit_v0_count", int'(o_dealt_count), 1);

        shuffle();
        deal(51, 1, 1'b0, r, s, l);
        check("lit_v51_rank", r, 13);
        check("lit_v51_suit", s, 3);
        deal(51, 0, 1'b0, r, s, l);
        check("lit_wrap_rank", r, 1);
        check("lit_wrap_suit", s, 0);
        check("lit_wrap_latency", l, 4);
`ifdef DEALER_PROBE_STATS_EN
        check("lit_wrap_probe", int'(o_probe_cycles), 2);
`endif
        deal(60, 0, 1'b0, r, s, l);
        check("lit_v60_rank", r, 9);
        check("lit_v60_suit", s, 0);

        deal(30, 10, 1'b1, r, s, l);
        check("lit_hold_count", int'(o_dealt_count), 4);

        // shuffle wins over deal when both are raised in IDLE
        i_deal = 1'b1; i_shuffle = 1'b1;
        @(posedge i_clk); #1;
        i_deal = 1'b0; i_shuffle = 1'b0;
        model_clear();
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        check("prio_no_request", int'(o_rng_request), 0);
        check("prio_busy", int'(o_busy), 0);

        for (int k = 0; k < N; k++)
            deal(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 1'b0, r, s, l);
        check("full_empty", int'(o_deck_empty), 1);
        check("full_count", int'(o_dealt_count), N);
        for (int i = 0; i < N; i++) check("all_dealt", int'(seen[i]), 1);

        i_rng_value = W'(5);
        i_deal = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            check("empty_no_request", int'(o_rng_request), 0);
            check("empty_not_busy", int'(o_busy), 0);
        end
        i_deal = 1'b0;
        shuffle();
        check("reshuffle_count", int'(o_dealt_count), 0);
        check("reshuffle_empty", int'(o_deck_empty), 0);

        for (int k = 10; k < 20; k++) deal(k, 0, 1'b0, r, s, l);
        i_rng_value = W'(10);
        i_deal = 1'b1;
        @(posedge i_clk); #1;
        i_deal = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("probing_busy", int'(o_busy), 1);
        i_rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        #1;
        check("abort_rng_request", int'(o_rng_request), 0);
        check("abort_valid", int'(o_card_valid), 0);
        check("abort_rank", int'(o_card_rank), 0);
        check("abort_suit", int'(o_card_suit), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_empty", int'(o_deck_empty), 0);
        check("abort_count", int'(o_dealt_count), 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        deal(20, 0, 1'b0, r, s, l);
        check("after_abort_rank", r, 8);
        check("after_abort_suit", s, 1);
        check("after_abort_latency", l, 3);
        check("after_abort_count", int'(o_dealt_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
